// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX serializer among NUM_REQ requesters.
// Optional watchdog (cycle limit WDOG_CYCLES, sticky err) is built when UART_TX_SCHED_WDOG_EN is defined.
module uart_tx_sched #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_BIT    = 8,
    parameter int MAX_BURST   = 16,
    parameter int WDOG_CYCLES = 2000000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0][DATA_BIT-1:0] req_data,
    input  logic [NUM_REQ-1:0]               req_last,
    output logic [NUM_REQ-1:0]               gnt,
    output logic                             tx_start,
    output logic [DATA_BIT-1:0]              tx_data,
    input  logic                             tx_busy,
    input  logic                             tx_done,
    output logic [$clog2(NUM_REQ)-1:0]       owner,
    output logic                             active,
    output logic                             err
);
    localparam int OW = $clog2(NUM_REQ);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                active_q, active_d;
    logic                last_q, last_d;
    logic [7:0]          burst_cnt_q, burst_cnt_d;
    logic [DATA_BIT-1:0] tx_data_q, tx_data_d;
    logic [OW-1:0]       winner;
    logic                found;
    logic [OW-1:0]       owner_inc;
    logic                timeout;
    logic                rel_now;

    // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!found && req[OW'(idx)]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

    assign owner_inc = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);

`ifdef UART_TX_SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;

    assign timeout = (state_q != IDLE) && (wdog_q == WW'(WDOG_CYCLES - 1));

    // Counter restarts whenever the FSM enters a new state, so each wait is bounded on its own.
    always_comb begin
        wdog_d = wdog_q + WW'(1);
        if (state_q == IDLE || state_d != state_q) begin
            wdog_d = '0;
        end
        err_d = err_q | timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        active_d    = active_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        tx_data_d   = tx_data_q;
        gnt         = '0;
        tx_start    = 1'b0;
        rel_now     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d     = winner;
                    active_d    = 1'b1;
                    burst_cnt_d = '0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (timeout) begin
                    rel_now = 1'b1;
                end else if (!tx_busy) begin
                    tx_start       = 1'b1;
                    gnt[owner_q]   = 1'b1;
                    tx_data_d      = req_data[owner_q];
                    last_d         = req_last[owner_q];
                    state_d        = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (timeout) begin
                    rel_now = 1'b1;
                end else if (tx_done) begin
                    if (!last_q && (burst_cnt_q < BURST_LAST) && req[owner_q]) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                        state_d     = LOAD;
                    end else begin
                        rel_now = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rel_now) begin
            state_d     = IDLE;
            active_d    = 1'b0;
            rr_ptr_d    = owner_inc;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            active_q    <= 1'b0;
            last_q      <= 1'b0;
            burst_cnt_q <= '0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            active_q    <= active_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // The byte is visible in the same cycle as tx_start and held afterwards.
    assign tx_data = tx_data_d;
    assign owner   = owner_q;
    assign active  = active_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table, hand-written corner sequences, randomized run with reference model.
module tb_uart_tx_sched;
    localparam int N  = 4;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N-1:0][7:0] req_data = '0;
    logic [N-1:0]      req_last = '0;
    logic [N-1:0]      gnt;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic              tx_done = 1'b0;
    logic [1:0]        owner;
    logic              active;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_sched #(.NUM_REQ(N), .DATA_BIT(8), .MAX_BURST(MB), .WDOG_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_done(tx_done), .owner(owner), .active(active), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  req;
        logic [31:0] data;
        logic [1:0]  exp_owner;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; req = '0; req_last = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
        tick();
        rst = 1'b0;
        smp();
    endtask

    // Serializer accepts the byte, shifts for two cycles, then pulses done; grant must be gone after.
    task automatic finish_pkt(input string nm);
        tick(); req = '0; tx_busy = 1'b1; tx_done = 1'b0;
        smp(); chk({nm, "_busy_gnt"}, 32'(gnt), 0);
        tick(); tx_done = 1'b1;
        smp(); chk({nm, "_done_active"}, 32'(active), 1);
        tick(); tx_done = 1'b0; tx_busy = 1'b0;
        smp(); chk({nm, "_release"}, 32'(active), 0);
    endtask

    // Random-run state
    bit        src_on[N];
    int        src_left[N];
    logic [7:0] src_data[N];
    bit        src_last[N];
    int        m_owner, m_owner_out, m_ptr, m_sent, ser_left, w;
    bit        m_due, m_inflight, m_last, exp_start;

    initial begin
        vecs[0]  = '{4'b0010, 32'h4433A511, 2'd1, 4'b0010, 8'hA5};
        vecs[1]  = '{4'b1111, 32'h13121110, 2'd2, 4'b0100, 8'h12};
        vecs[2]  = '{4'b1111, 32'h23222120, 2'd3, 4'b1000, 8'h23};
        vecs[3]  = '{4'b1111, 32'h33323130, 2'd0, 4'b0001, 8'h30};
        vecs[4]  = '{4'b1111, 32'h43424140, 2'd1, 4'b0010, 8'h41};
        vecs[5]  = '{4'b1111, 32'h53525150, 2'd2, 4'b0100, 8'h52};
        vecs[6]  = '{4'b1111, 32'h63626160, 2'd3, 4'b1000, 8'h63};
        vecs[7]  = '{4'b1111, 32'h73727170, 2'd0, 4'b0001, 8'h70};
        vecs[8]  = '{4'b0001, 32'h83828180, 2'd0, 4'b0001, 8'h80};
        vecs[9]  = '{4'b1000, 32'h93929190, 2'd3, 4'b1000, 8'h93};
        vecs[10] = '{4'b0110, 32'hA3A2A1A0, 2'd1, 4'b0010, 8'hA1};
        vecs[11] = '{4'b0011, 32'hB3B2B1B0, 2'd0, 4'b0001, 8'hB0};
        vecs[12] = '{4'b1100, 32'hC3C2C1C0, 2'd2, 4'b0100, 8'hC2};
        vecs[13] = '{4'b0101, 32'hD3D2D1D0, 2'd0, 4'b0001, 8'hD0};
        vecs[14] = '{4'b1010, 32'hE3E2E1E0, 2'd1, 4'b0010, 8'hE1};

        do_reset();
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_err", 32'(err), 0);

        // Single-byte packets; round-robin pointer carries from row to row.
        for (int r = 0; r < 15; r++) begin
            tick(); req = vecs[r].req; req_data = vecs[r].data; req_last = 4'hF;
            tx_busy = 1'b0; tx_done = 1'b0;
            smp(); chk($sformatf("row%0d_idle_start", r), 32'(tx_start), 0);
            tick();
            smp();
            chk($sformatf("row%0d_start", r), 32'(tx_start), 1);
            chk($sformatf("row%0d_gnt", r), 32'(gnt), 32'(vecs[r].exp_gnt));
            chk($sformatf("row%0d_owner", r), 32'(owner), 32'(vecs[r].exp_owner));
            chk($sformatf("row%0d_data", r), 32'(tx_data), 32'(vecs[r].exp_data));
            chk($sformatf("row%0d_active", r), 32'(active), 1);
            finish_pkt($sformatf("row%0d", r));
        end

        // Burst limit: pointer is 2, requester 2 streams non-last bytes, requester 0 waits.
        tick(); req = 4'b0101; req_last = 4'b0000; req_data = '0;
        req_data[0] = 8'h0F; req_data[2] = 8'h20; tx_busy = 1'b0; tx_done = 1'b0;
        smp(); chk("burst_idle", 32'(active), 0);
        for (int k = 0; k < MB; k++) begin
            tick(); tx_busy = 1'b0; tx_done = 1'b0; req_data[2] = 8'(8'h20 + k);
            smp();
            chk($sformatf("burst%0d_start", k), 32'(tx_start), 1);
            chk($sformatf("burst%0d_gnt", k), 32'(gnt), 32'b0100);
            chk($sformatf("burst%0d_data", k), 32'(tx_data), 32'(8'h20 + k));
            tick(); tx_busy = 1'b1;
            smp(); chk($sformatf("burst%0d_nostart", k), 32'(tx_start), 0);
            tick(); tx_done = 1'b1;
            smp(); chk($sformatf("burst%0d_owner", k), 32'(owner), 2);
        end
        tick(); tx_busy = 1'b0; tx_done = 1'b0;
        smp();
        chk("burst_released", 32'(active), 0);
        chk("burst_released_start", 32'(tx_start), 0);
        tick();
        smp();
        chk("burst_next_gnt", 32'(gnt), 32'b0001);
        chk("burst_next_owner", 32'(owner), 0);
        chk("burst_next_data", 32'(tx_data), 32'h0F);
        finish_pkt("burst_next");

        // Busy stall in LOAD for 10 cycles.
        tick(); req = 4'b0010; req_last = 4'hF; req_data = '0; req_data[1] = 8'h5A; tx_busy = 1'b1;
        smp();
        for (int c = 0; c < 10; c++) begin
            tick();
            smp();
            chk($sformatf("stall%0d_start", c), 32'(tx_start), 0);
            chk($sformatf("stall%0d_gnt", c), 32'(gnt), 0);
            chk($sformatf("stall%0d_active", c), 32'(active), 1);
        end
        tick(); tx_busy = 1'b0;
        smp();
        chk("stall_end_start", 32'(tx_start), 1);
        chk("stall_end_gnt", 32'(gnt), 32'b0010);
        chk("stall_end_data", 32'(tx_data), 32'h5A);
        finish_pkt("stall");

        // Reset while waiting for the serializer; a stray tx_done afterwards must be ignored.
        tick(); req = 4'b0100; req_last = 4'h0; req_data = 32'h00770000; tx_busy = 1'b0;
        smp();
        tick();
        smp(); chk("rmid_start", 32'(tx_start), 1);
        tick(); tx_busy = 1'b1;
        smp();
        tick(); rst = 1'b1;
        smp(); chk("rmid_wait_active", 32'(active), 1);
        tick(); rst = 1'b0; req = '0; tx_busy = 1'b0;
        smp();
        chk("rmid_active", 32'(active), 0);
        chk("rmid_owner", 32'(owner), 0);
        chk("rmid_start0", 32'(tx_start), 0);
        tick(); tx_done = 1'b1;
        smp();
        chk("rmid_stray_gnt", 32'(gnt), 0);
        chk("rmid_stray_start", 32'(tx_start), 0);
        tick(); tx_done = 1'b0; req = 4'b1010; req_last = 4'hF; req_data = 32'h99887766;
        smp(); chk("rmid_idle", 32'(active), 0);
        tick();
        smp();
        chk("rmid_ptr_gnt", 32'(gnt), 32'b0010);
        chk("rmid_ptr_data", 32'(tx_data), 32'h77);
        finish_pkt("rmid");

`ifdef UART_TX_SCHED_WDOG_EN
        do_reset();
        tick(); req = 4'b0001; req_last = 4'hF; req_data = 32'h000000AA;
        smp();
        tick();
        smp(); chk("wd_start", 32'(tx_start), 1);
        for (int c = 1; c <= 50; c++) begin
            tick(); req = '0; tx_busy = 1'b1;
            smp();
            chk($sformatf("wd%0d_active", c), 32'(active), 1);
            chk($sformatf("wd%0d_err", c), 32'(err), 0);
        end
        tick();
        smp();
        chk("wd_release", 32'(active), 0);
        chk("wd_err", 32'(err), 1);
        tick(); req = 4'b0010;
        smp();
        for (int c = 0; c < 50; c++) begin
            tick();
            if (c == 49) req = '0;
            smp();
            chk($sformatf("wdl%0d_gnt", c), 32'(gnt), 0);
            chk($sformatf("wdl%0d_active", c), 32'(active), 1);
        end
        tick();
        smp();
        chk("wdl_release", 32'(active), 0);
        chk("wdl_err", 32'(err), 1);
        tick(); req = 4'b0100; tx_busy = 1'b0;
        smp();
        tick();
        smp(); chk("wd_after_start", 32'(tx_start), 1);
        finish_pkt("wd_after");
        chk("wd_sticky", 32'(err), 1);
`endif

        // Randomized run against the transaction-level model.
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_on[i] = 1'b0; src_left[i] = 0; src_data[i] = '0; src_last[i] = 1'b0;
        end
        m_owner = -1; m_owner_out = 0; m_ptr = 0; m_sent = 0; ser_left = 0;
        m_due = 1'b0; m_inflight = 1'b0; m_last = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!src_on[i] && $urandom_range(0, 7) == 0) begin
                    src_on[i]   = 1'b1;
                    src_left[i] = int'($urandom_range(1, 6));
                    src_data[i] = 8'($urandom);
                    src_last[i] = (src_left[i] == 1);
                end
                req[i]      = src_on[i];
                req_data[i] = src_data[i];
                req_last[i] = src_last[i];
            end
            tx_busy = (ser_left > 0);
            tx_done = (ser_left == 1) || (ser_left == 0 && $urandom_range(0, 15) == 0);
            smp();

            exp_start = m_due && !tx_busy;
            chk("rnd_start", 32'(tx_start), 32'(exp_start));
            chk("rnd_gnt", 32'(gnt), exp_start ? (32'd1 << m_owner) : 32'd0);
            if (exp_start) chk("rnd_data", 32'(tx_data), 32'(src_data[m_owner]));
            chk("rnd_active", 32'(active), 32'(m_owner >= 0));
            chk("rnd_owner", 32'(owner), 32'(m_owner_out));
            chk("rnd_err", 32'(err), 0);

            if (ser_left > 0) ser_left--;
            if (tx_start) ser_left = int'($urandom_range(1, 4));

            if (m_owner < 0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                if (w >= 0) begin
                    m_owner = w; m_owner_out = w; m_due = 1'b1; m_sent = 0;
                end
            end else if (m_due) begin
                if (!tx_busy) begin
                    m_due = 1'b0; m_inflight = 1'b1; m_last = src_last[m_owner]; m_sent++;
                    src_left[m_owner]--;
                    if (src_left[m_owner] == 0 || $urandom_range(0, 9) == 0) begin
                        src_on[m_owner] = 1'b0; src_left[m_owner] = 0;
                    end else begin
                        src_data[m_owner] = 8'($urandom);
                        src_last[m_owner] = (src_left[m_owner] == 1);
                    end
                end
            end else if (m_inflight && tx_done) begin
                m_inflight = 1'b0;
                if (!m_last && m_sent < MB && req[m_owner]) begin
                    m_due = 1'b1;
                end else begin
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end

        tick(); rst = 1'b1; req = '0;
        tick(); rst = 1'b0;
        smp(); chk("final_err", 32'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmit serializer among NUM_REQ requesters.
- Each requester presents a byte and a packet-end flag.
- The scheduler grants one requester, feeds bytes to the serializer with a start/busy/done handshake, and holds the grant until the packet ends or the burst limit is reached.
- Sits between on-board producers (receive-buffer echo path, LED/status reporter, debug source) and the single TX line of the board.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- DATA_BIT, 8, bits per character.
- MAX_BURST, 16, maximum bytes sent per grant before forced release; 1..255.
- WDOG_CYCLES, 2000000, watchdog limit in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester byte-valid; held until the matching gnt bit.
- req_data  input  NUM_REQ x DATA_BIT  per-requester byte (packed array, index = requester).
- req_last  input  NUM_REQ  per-requester packet-end flag, qualified with req.
- gnt  output  NUM_REQ  one-hot, one-cycle pulse: byte of that requester accepted.
- tx_start  output  1  one-cycle pulse to the serializer.
- tx_data  output  DATA_BIT  byte to the serializer; valid while tx_start=1, held afterwards.
- tx_busy  input  1  serializer is shifting.
- tx_done  input  1  one-cycle pulse: serializer finished the stop bit.
- owner  output  $clog2(NUM_REQ)  index of the current grant holder.
- active  output  1  a grant is held.
- err  output  1  sticky watchdog error; tied to 0 without the optional feature.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst. All state updates on posedge clk.
- Reset values: state=IDLE, gnt=0, tx_start=0, tx_data=0, owner=0, active=0, err=0, rr_ptr=0, burst_cnt=0.
- Reset mid-operation: the abort is immediate. tx_start is 0 from the next cycle. The serializer is not reset by this block. Any later tx_done is ignored in IDLE.
- States: IDLE, LOAD, WAIT_DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... with modulo-NUM_REQ wrap.
  - owner <= winner, active <= 1, burst_cnt <= 0, then go to LOAD.
  - No req: stay in IDLE, outputs unchanged.
- LOAD:
  - If tx_busy=0: tx_start=1, tx_data <= req_data[owner], gnt[owner]=1 for this cycle. Capture last_q <= req_last[owner]. Go to WAIT_DONE.
  - If tx_busy=1: stay in LOAD with tx_start=0 and no gnt.
- WAIT_DONE, on tx_done=1:
  - Continue (back to LOAD, burst_cnt+1, same owner) only if all hold: last_q=0, burst_cnt < MAX_BURST-1, and req[owner]=1 in that cycle.
  - Otherwise release: state IDLE, active <= 0, rr_ptr <= (owner+1) mod NUM_REQ, burst_cnt <= 0.
  - tx_done=0: stay.
- Latency:
  - req rising in IDLE at cycle N gives tx_start and gnt at cycle N+1 when tx_busy=0.
  - Back-to-back bytes in a burst: tx_done at cycle M gives the next tx_start at cycle M+1.
- tx_done outside WAIT_DONE: ignored.
- Requester drops req mid-burst (before its gnt): the grant is released at the next tx_done and no byte is taken from it.
- Other requesters' req changes never affect an active grant. There is no preemption.
- At most one gnt bit is ever high. gnt is never high without tx_start in the same cycle.
- Wrap-around: owner=NUM_REQ-1 on release gives rr_ptr=0.

Optional Feature:
- Macro: UART_TX_SCHED_WDOG_EN.
- Defined:
  - A cycle counter runs in LOAD and WAIT_DONE and clears on each state entry.
  - Reaching WDOG_CYCLES-1 forces release exactly as a normal release, and sets err=1.
  - err stays 1 until rst.
  - No gnt is issued for an aborted byte that was still waiting in LOAD.
- Undefined: no counter is built, err is constant 0, and the block waits indefinitely for tx_busy and tx_done.

Test Plan:
- Single requester, one byte: req[1]=1, req_data[1]=8'hA5, req_last[1]=1, tx_busy=0 → tx_start and gnt=4'b0010 one cycle later, tx_data=8'hA5, owner=1. tx_done → active=0 next cycle, rr_ptr=2.
- Round-robin fairness: req=4'b1111 held, all req_last=1 → grant order 0,1,2,3,0 on successive packets; gnt one-hot every time.
- Burst hold and limit: MAX_BURST=4, req[2] held with req_last=0, req[0] also high → four consecutive bytes to owner 2, then release and owner=3 skipped, owner=0 next.
- Busy stall: enter LOAD with tx_busy=1 for 10 cycles → tx_start=0 and gnt=0 throughout; tx_busy falls → tx_start on the following cycle.
- Reset mid-burst: rst=1 during WAIT_DONE → next cycle active=0, owner=0, tx_start=0. A stray tx_done afterwards produces no gnt.
- Watchdog (UART_TX_SCHED_WDOG_EN, WDOG_CYCLES=50): grant issued, tx_done never pulses → release 50 cycles after entering WAIT_DONE, err=1 and sticky until rst.
